stk_pipe_mem_seq: RTL and testbench

//  Per-bank request sequencer and initiator for one bank of the stack line memory (head, tail, data SRAMs).
//  - Accepts line read/write commands on a valid/ready port.
//  - Drives ce/oe/addr/din to all three SRAMs in lock-step.
//  - Captures 1-cycle SRAM read data and returns it, tagged, through a credit-managed response FIFO.
//  - One instance per bank, sitting between the stack pipeline and the bank SRAMs.

---
 rtl/stk_pipe_mem_seq.sv | 148 ++++++++++++++
 tb/tb_stk_pipe_mem_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stk_pipe_mem_seq.sv
// Per-bank request sequencer for the stack line memory: drives the head/tail/data SRAMs
// in lock-step and returns tagged read data through a credit-managed response FIFO.
module stk_pipe_mem_seq #(
    parameter int LINE_W    = 10,
    parameter int DAT_W     = 128,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              arst,

    input  logic              i_cmd_vld,
    output logic              o_cmd_rdy,
    input  logic              i_cmd_wr,
    input  logic [2:0]        i_cmd_wen,
    input  logic [LINE_W-1:0] i_cmd_addr,
    input  logic [LINE_W-1:0] i_cmd_head,
    input  logic [LINE_W-1:0] i_cmd_tail,
    input  logic [DAT_W-1:0]  i_cmd_dat,
    input  logic [TAG_W-1:0]  i_cmd_tag,

    output logic              o_rsp_vld,
    input  logic              i_rsp_rdy,
    output logic [TAG_W-1:0]  o_rsp_tag,
    output logic [LINE_W-1:0] o_rsp_head,
    output logic [LINE_W-1:0] o_rsp_tail,
    output logic [DAT_W-1:0]  o_rsp_dat,

    output logic              o_head_ce,
    output logic              o_head_oe,
    output logic [LINE_W-1:0] o_head_addr,
    output logic [LINE_W-1:0] o_head_din,
    input  logic [LINE_W-1:0] i_head_dout,

    output logic              o_tail_ce,
    output logic              o_tail_oe,
    output logic [LINE_W-1:0] o_tail_addr,
    output logic [LINE_W-1:0] o_tail_din,
    input  logic [LINE_W-1:0] i_tail_dout,

    output logic              o_dat_ce,
    output logic              o_dat_oe,
    output logic [LINE_W-1:0] o_dat_addr,
    output logic [DAT_W-1:0]  o_dat_din,
    input  logic [DAT_W-1:0]  i_dat_dout,

    output logic              o_idle
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int ENT_W = TAG_W + 2 * LINE_W + DAT_W;

    logic [CNT_W-1:0] r_credits;
    logic [CNT_W-1:0] r_fifo_cnt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_inflight_p1;
    logic [TAG_W-1:0] r_tag_p1;
    logic [ENT_W-1:0] r_fifo_mem [RSP_DEPTH];

    logic             w_acc;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_push;
    logic             w_pop;
    logic [2:0]       w_ce;
    logic [ENT_W-1:0] w_rsp_ent;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(RSP_DEPTH - 1))
            return '0;
        else
            return ptr + PTR_W'(1);
    endfunction

    // Stage 0: command accept and combinational SRAM drive
    assign o_cmd_rdy = (r_credits != '0);
    assign w_acc     = i_cmd_vld & o_cmd_rdy;
    assign w_rd_acc  = w_acc & ~i_cmd_wr;
    assign w_wr_acc  = w_acc & i_cmd_wr;

    always_comb begin
        w_ce = 3'b000;
        if (w_rd_acc)
            w_ce = 3'b111;
        else if (w_wr_acc)
            w_ce = i_cmd_wen;
    end

    // Address and write data are forced to 0 whenever the matching ce is low.
    assign o_head_ce   = w_ce[0];
    assign o_head_oe   = w_rd_acc;
    assign o_head_addr = w_ce[0] ? i_cmd_addr : '0;
    assign o_head_din  = (w_ce[0] & w_wr_acc) ? i_cmd_head : '0;

    assign o_tail_ce   = w_ce[1];
    assign o_tail_oe   = w_rd_acc;
    assign o_tail_addr = w_ce[1] ? i_cmd_addr : '0;
    assign o_tail_din  = (w_ce[1] & w_wr_acc) ? i_cmd_tail : '0;

    assign o_dat_ce    = w_ce[2];
    assign o_dat_oe    = w_rd_acc;
    assign o_dat_addr  = w_ce[2] ? i_cmd_addr : '0;
    assign o_dat_din   = (w_ce[2] & w_wr_acc) ? i_cmd_dat : '0;

    // Stage 1: SRAM data lands, pushed into the response FIFO
    assign w_push = r_inflight_p1;
    assign w_pop  = o_rsp_vld & i_rsp_rdy;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_inflight_p1 <= 1'b0;
            r_credits     <= CNT_W'(RSP_DEPTH);
            r_fifo_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            r_inflight_p1 <= w_rd_acc;
            r_credits     <= r_credits + CNT_W'(w_pop) - CNT_W'(w_rd_acc);
            r_fifo_cnt    <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
            if (w_push)
                r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_next(r_rd_ptr);
        end
    end

    // Credits bound the number of outstanding reads, so a push never finds the FIFO full.
    always_ff @(posedge clk) begin
        if (w_rd_acc)
            r_tag_p1 <= i_cmd_tag;
        if (w_push)
            r_fifo_mem[r_wr_ptr] <= {r_tag_p1, i_head_dout, i_tail_dout, i_dat_dout};
    end

    // Stage 2: FIFO head presented; payload masked to 0 while empty
    assign o_rsp_vld = (r_fifo_cnt != '0);
    assign w_rsp_ent = o_rsp_vld ? r_fifo_mem[r_rd_ptr] : '0;

    assign o_rsp_tag  = w_rsp_ent[ENT_W-1 -: TAG_W];
    assign o_rsp_head = w_rsp_ent[2*LINE_W+DAT_W-1 -: LINE_W];
    assign o_rsp_tail = w_rsp_ent[LINE_W+DAT_W-1 -: LINE_W];
    assign o_rsp_dat  = w_rsp_ent[DAT_W-1:0];

    assign o_idle = ~r_inflight_p1 & (r_fifo_cnt == '0);

endmodule

// File: tb/tb_stk_pipe_mem_seq.sv
// Randomised and directed bench for stk_pipe_mem_seq with SRAM models and a
// queue-based reference of outstanding reads.
module tb_stk_pipe_mem_seq;

    localparam int LINE_W = 10;
    localparam int DAT_W  = 128;
    localparam int TAG_W  = 4;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic              cmd_vld = 1'b0;
    logic              cmd_rdy;
    logic              cmd_wr = 1'b0;
    logic [2:0]        cmd_wen = 3'b000;
    logic [LINE_W-1:0] cmd_addr = '0;
    logic [LINE_W-1:0] cmd_head = '0;
    logic [LINE_W-1:0] cmd_tail = '0;
    logic [DAT_W-1:0]  cmd_dat = '0;
    logic [TAG_W-1:0]  cmd_tag = '0;
    logic              rsp_vld;
    logic              rsp_rdy = 1'b0;
    logic [TAG_W-1:0]  rsp_tag;
    logic [LINE_W-1:0] rsp_head, rsp_tail;
    logic [DAT_W-1:0]  rsp_dat;
    logic              head_ce, head_oe, tail_ce, tail_oe, dat_ce, dat_oe;
    logic [LINE_W-1:0] head_addr, head_din, tail_addr, tail_din, dat_addr;
    logic [DAT_W-1:0]  dat_din;
    logic [LINE_W-1:0] head_dout = '0;
    logic [LINE_W-1:0] tail_dout = '0;
    logic [DAT_W-1:0]  dat_dout = '0;
    logic              idle;

    stk_pipe_mem_seq #(.LINE_W(LINE_W), .DAT_W(DAT_W), .TAG_W(TAG_W), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .arst(arst),
        .i_cmd_vld(cmd_vld), .o_cmd_rdy(cmd_rdy), .i_cmd_wr(cmd_wr), .i_cmd_wen(cmd_wen),
        .i_cmd_addr(cmd_addr), .i_cmd_head(cmd_head), .i_cmd_tail(cmd_tail),
        .i_cmd_dat(cmd_dat), .i_cmd_tag(cmd_tag),
        .o_rsp_vld(rsp_vld), .i_rsp_rdy(rsp_rdy), .o_rsp_tag(rsp_tag),
        .o_rsp_head(rsp_head), .o_rsp_tail(rsp_tail), .o_rsp_dat(rsp_dat),
        .o_head_ce(head_ce), .o_head_oe(head_oe), .o_head_addr(head_addr),
        .o_head_din(head_din), .i_head_dout(head_dout),
        .o_tail_ce(tail_ce), .o_tail_oe(tail_oe), .o_tail_addr(tail_addr),
        .o_tail_din(tail_din), .i_tail_dout(tail_dout),
        .o_dat_ce(dat_ce), .o_dat_oe(dat_oe), .o_dat_addr(dat_addr),
        .o_dat_din(dat_din), .i_dat_dout(dat_dout),
        .o_idle(idle)
    );

    always #5 clk = ~clk;

    // SRAM models: 1-cycle read latency, write on ce & !oe
    logic [LINE_W-1:0] head_mem [1 << LINE_W];
    logic [LINE_W-1:0] tail_mem [1 << LINE_W];
    logic [DAT_W-1:0]  dat_mem  [1 << LINE_W];

    always @(posedge clk) begin
        if (head_ce) begin
            if (head_oe) head_dout <= head_mem[head_addr];
            else         head_mem[head_addr] <= head_din;
        end
        if (tail_ce) begin
            if (tail_oe) tail_dout <= tail_mem[tail_addr];
            else         tail_mem[tail_addr] <= tail_din;
        end
        if (dat_ce) begin
            if (dat_oe) dat_dout <= dat_mem[dat_addr];
            else        dat_mem[dat_addr] <= dat_din;
        end
    end

    // Reference: golden line contents plus queue of reads not yet consumed
    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [LINE_W-1:0] head;
        logic [LINE_W-1:0] tail;
        logic [DAT_W-1:0]  dat;
        int                avail;
    } rsp_t;

    logic [LINE_W-1:0] g_head [1 << LINE_W];
    logic [LINE_W-1:0] g_tail [1 << LINE_W];
    logic [DAT_W-1:0]  g_dat  [1 << LINE_W];
    rsp_t              q[$];
    int                cyc = 0;
    int                total = 0;
    int                bad = 0;

    task automatic chk(input string nm, input logic [DAT_W-1:0] got, input logic [DAT_W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic step(output bit acc);
        bit         exp_rdy, exp_vld, pop;
        logic [2:0] ece, eoe;
        rsp_t       r;
        @(negedge clk);
        exp_rdy = (q.size() < DEPTH);
        exp_vld = (q.size() > 0) && (q[0].avail <= cyc);
        acc = cmd_vld && exp_rdy;
        pop = exp_vld && rsp_rdy;
        ece = !acc ? 3'b000 : (cmd_wr ? cmd_wen : 3'b111);
        eoe = (acc && !cmd_wr) ? 3'b111 : 3'b000;
        chk("cmd_rdy", cmd_rdy, exp_rdy);
        chk("rsp_vld", rsp_vld, exp_vld);
        chk("idle", idle, q.size() == 0);
        chk("ce", {dat_ce, tail_ce, head_ce}, ece);
        chk("oe", {dat_oe, tail_oe, head_oe}, eoe);
        if (ece[0]) chk("head_addr", head_addr, cmd_addr);
        if (ece[1]) chk("tail_addr", tail_addr, cmd_addr);
        if (ece[2]) chk("dat_addr", dat_addr, cmd_addr);
        if (acc && cmd_wr) begin
            if (ece[0]) chk("head_din", head_din, cmd_head);
            if (ece[1]) chk("tail_din", tail_din, cmd_tail);
            if (ece[2]) chk("dat_din", dat_din, cmd_dat);
        end
        if (exp_vld) begin
            chk("rsp_tag", rsp_tag, q[0].tag);
            chk("rsp_head", rsp_head, q[0].head);
            chk("rsp_tail", rsp_tail, q[0].tail);
            chk("rsp_dat", rsp_dat, q[0].dat);
        end
        @(posedge clk);
        if (pop) q.delete(0);
        if (acc) begin
            if (cmd_wr) begin
                if (cmd_wen[0]) g_head[cmd_addr] = cmd_head;
                if (cmd_wen[1]) g_tail[cmd_addr] = cmd_tail;
                if (cmd_wen[2]) g_dat[cmd_addr]  = cmd_dat;
            end else begin
                r.tag = cmd_tag; r.head = g_head[cmd_addr]; r.tail = g_tail[cmd_addr];
                r.dat = g_dat[cmd_addr]; r.avail = cyc + 2;
                q.push_back(r);
            end
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input bit wr, input logic [2:0] wen, input logic [LINE_W-1:0] a,
                         input logic [LINE_W-1:0] h, input logic [LINE_W-1:0] t,
                         input logic [DAT_W-1:0] d, input logic [TAG_W-1:0] tg);
        bit acc = 1'b0;
        int n = 0;
        cmd_vld = 1'b1; cmd_wr = wr; cmd_wen = wen; cmd_addr = a;
        cmd_head = h; cmd_tail = t; cmd_dat = d; cmd_tag = tg;
        while (!acc && n < 20) begin
            step(acc);
            n++;
        end
        if (!acc) chk("issue_timeout", cmd_rdy, 1'b1);
        cmd_vld = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        bit acc;
        cmd_vld = 1'b0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        cmd_vld = 1'b0;
        rsp_rdy = 1'b1;
        while (q.size() != 0 && n < 50) begin
            step(acc);
            n++;
        end
        chk("drain_empty", q.size(), 0);
        step(acc);
    endtask

    initial begin
        bit acc;
        for (int i = 0; i < (1 << LINE_W); i++) begin
            head_mem[i] = '0; tail_mem[i] = '0; dat_mem[i] = '0;
            g_head[i] = '0; g_tail[i] = '0; g_dat[i] = '0;
        end

        // Reset and idle state
        @(negedge clk);
        chk("rst_rdy", cmd_rdy, 1'b1);
        chk("rst_idle", idle, 1'b1);
        chk("rst_vld", rsp_vld, 1'b0);
        chk("rst_ce", {dat_ce, tail_ce, head_ce}, 3'b000);
        chk("rst_oe", {dat_oe, tail_oe, head_oe}, 3'b000);
        @(posedge clk); #1;
        arst = 1'b0;
        rsp_rdy = 1'b1;
        idle_cycles(2);

        // Full write then immediate read of the same line
        issue(1'b1, 3'b111, 10'h005, 10'h012, 10'h034, {16{8'hA5}}, 4'd3);
        issue(1'b0, 3'b000, 10'h005, '0, '0, '0, 4'd3);
        idle_cycles(4);

        // Head-only write, then a write with no enables (must not change the line)
        issue(1'b1, 3'b001, 10'h007, 10'h3FF, 10'h155, {4{32'hDEADBEEF}}, 4'd0);
        issue(1'b0, 3'b000, 10'h007, '0, '0, '0, 4'd5);
        issue(1'b1, 3'b000, 10'h007, 10'h111, 10'h222, {4{32'h12345678}}, 4'd0);
        issue(1'b0, 3'b000, 10'h007, '0, '0, '0, 4'd6);
        idle_cycles(4);

        // Credit stall with the response port blocked
        rsp_rdy = 1'b0;
        issue(1'b0, 3'b000, 10'h005, '0, '0, '0, 4'd0);
        issue(1'b0, 3'b000, 10'h007, '0, '0, '0, 4'd1);
        cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h005; cmd_tag = 4'd2;
        for (int i = 0; i < 3; i++) step(acc);
        rsp_rdy = 1'b1;
        step(acc);
        rsp_rdy = 1'b0;
        issue(1'b0, 3'b000, 10'h005, '0, '0, '0, 4'd2);
        idle_cycles(3);
        drain();

        // Streaming reads with the response port always ready
        rsp_rdy = 1'b1;
        cmd_vld = 1'b1; cmd_wr = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cmd_addr = LINE_W'(i % 8);
            cmd_tag  = TAG_W'(i);
            step(acc);
        end
        drain();

        // Random traffic over a small address range to provoke hazards
        for (int i = 0; i < 300; i++) begin
            cmd_vld  = ($urandom_range(0, 9) < 7);
            cmd_wr   = ($urandom_range(0, 9) < 4);
            cmd_wen  = 3'($urandom_range(0, 7));
            cmd_addr = LINE_W'($urandom_range(0, 7));
            cmd_head = LINE_W'($urandom_range(0, 1023));
            cmd_tail = LINE_W'($urandom_range(0, 1023));
            cmd_dat  = {$urandom, $urandom, $urandom, $urandom};
            cmd_tag  = TAG_W'($urandom_range(0, 15));
            rsp_rdy  = ($urandom_range(0, 3) != 0);
            step(acc);
        end
        drain();

        // Reset asserted the cycle after a read is accepted
        rsp_rdy = 1'b1;
        issue(1'b0, 3'b000, 10'h005, '0, '0, '0, 4'd9);
        arst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("mid_rst_vld", rsp_vld, 1'b0);
        chk("mid_rst_idle", idle, 1'b1);
        chk("mid_rst_rdy", cmd_rdy, 1'b1);
        @(posedge clk); #1;
        cyc++;
        arst = 1'b0;
        idle_cycles(4);

        // Both credits restored: exactly two reads accepted with the port blocked
        rsp_rdy = 1'b0;
        issue(1'b0, 3'b000, 10'h007, '0, '0, '0, 4'd10);
        issue(1'b0, 3'b000, 10'h005, '0, '0, '0, 4'd11);
        cmd_vld = 1'b1; cmd_wr = 1'b0; cmd_addr = 10'h007; cmd_tag = 4'd12;
        for (int i = 0; i < 3; i++) step(acc);
        cmd_vld = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
